// File: rtl/nn_drv_pkg.sv
// nn_drv_pkg: shared types and sign-magnitude helpers for the inference driver
package nn_drv_pkg;
  typedef enum logic [2:0] {LOAD, START, WAIT, SCAN, OUT} state_t;
  localparam int SM_MAG_W = 31;
  typedef struct packed {
    logic sign;
    logic [SM_MAG_W-1:0] mag;
  } sm_t;
  function automatic int class_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int CW = class_w(1);
  function automatic logic sm_gt(input sm_t a, input sm_t b);
    logic an;
    logic bn;
    an = a.sign && a.mag != '0;
    bn = b.sign && b.mag != '0;
    return an != bn ? bn : (an ? a.mag < b.mag : a.mag > b.mag);
  endfunction
endpackage

// File: rtl/nn_argmax_scan.sv
// nn_argmax_scan: captures the network outputs and walks them one per cycle keeping the sign-magnitude maximum
module nn_argmax_scan
  import nn_drv_pkg::*;
#(
  parameter int BIT_WIDTH   = 9,
  parameter int NUM_OUTPUTS = 1,
  parameter int CLS_W       = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start_i,
  input  logic [NUM_OUTPUTS-1:0][BIT_WIDTH-1:0]  outputs_i,
  output logic                                   busy_o,
  output logic                                   done_o,
  output logic [CLS_W-1:0]                       class_o,
  output logic [BIT_WIDTH-1:0]                   score_o
);
  logic [NUM_OUTPUTS-1:0][BIT_WIDTH-1:0] bank_q;
  logic [CLS_W-1:0] idx_q;
  logic [CLS_W-1:0] cls_q;
  logic [BIT_WIDTH-1:0] score_q;
  logic [BIT_WIDTH-1:0] cur;
  logic busy_q, done_q, last, take;
  sm_t cand, best;
  assign cur = bank_q[idx_q];
  assign cand = {cur[BIT_WIDTH-1], SM_MAG_W'(cur[BIT_WIDTH-2:0])};
  assign best = {score_q[BIT_WIDTH-1], SM_MAG_W'(score_q[BIT_WIDTH-2:0])};
  assign last = idx_q == CLS_W'(NUM_OUTPUTS - 1);
  // element 0 seeds the max; later ones replace it only when strictly greater, so ties keep the lowest index
  assign take = idx_q == '0 || sm_gt(cand, best);
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign class_o = cls_q;
  assign score_o = score_q;
  // capture bank on start, then one comparison per busy cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_q  <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cls_q   <= '0;
      score_q <= '0;
    end else begin
      busy_q <= start_i || (busy_q && !last);
      done_q <= busy_q && last;
      idx_q  <= start_i ? '0 : busy_q ? idx_q + CLS_W'(1) : idx_q;
      if (start_i) bank_q <= outputs_i;
      if (busy_q && take) begin
        cls_q   <= idx_q;
        score_q <= cur;
      end
    end
  end
endmodule

// File: rtl/nn_inference_driver.sv
// nn_inference_driver: loads an input vector, runs the network via start/done, returns the argmax class (NN_DRV_TIMEOUT_EN adds a done watchdog)
module nn_inference_driver
  import nn_drv_pkg::*;
#(
  parameter int FRACTION_WIDTH = 4,
  parameter int BIT_WIDTH      = 9,
  parameter int NUM_INPUTS     = 2,
  parameter int NUM_OUTPUTS    = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  input  logic [BIT_WIDTH-1:0]                             in_data,
  input  logic                                             in_last,
  output logic                                             nn_start,
  input  logic                                             nn_done,
  output logic [NUM_INPUTS-1:0][BIT_WIDTH-1:0]             nn_inputs,
  input  logic [NUM_OUTPUTS-1:0][BIT_WIDTH-1:0]            nn_outputs,
  output logic                                             res_valid,
  input  logic                                             res_ready,
  output logic [class_w(NUM_OUTPUTS)-1:0]                  res_class,
  output logic [BIT_WIDTH-1:0]                             res_score,
  output logic                                             err_len,
  output logic                                             err_timeout
);
  localparam int IW = class_w(NUM_INPUTS);
  localparam int CLS_W = class_w(NUM_OUTPUTS);
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NUM_INPUTS-1:0][BIT_WIDTH-1:0] vec_q;
  logic err_len_q, err_len_d, accept, scan_start, scan_busy, scan_done, timeout_hit;
  assign in_ready = state_q == LOAD && !scan_busy && rst;
  assign accept = in_valid && in_ready;
  assign nn_start = state_q == START;
  assign res_valid = state_q == OUT;
  assign nn_inputs = vec_q;
  assign err_len = err_len_q;
  assign scan_start = state_q == WAIT && nn_done;
  nn_argmax_scan #(
    .BIT_WIDTH  (BIT_WIDTH),
    .NUM_OUTPUTS(NUM_OUTPUTS),
    .CLS_W      (CLS_W)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .start_i  (scan_start),
    .outputs_i(nn_outputs),
    .busy_o   (scan_busy),
    .done_o   (scan_done),
    .class_o  (res_class),
    .score_o  (res_score)
  );
`ifdef NN_DRV_TIMEOUT_EN
  localparam int TW = class_w(TIMEOUT_CYCLES);
  logic [TW-1:0] wcnt_q;
  logic err_to_q;
  assign timeout_hit = state_q == WAIT && !nn_done && wcnt_q == TW'(TIMEOUT_CYCLES - 1);
  assign err_timeout = err_to_q;
  // watchdog counts WAIT cycles from zero and clears everywhere else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt_q   <= '0;
      err_to_q <= 1'b0;
    end else begin
      wcnt_q   <= state_q == WAIT ? wcnt_q + TW'(1) : '0;
      err_to_q <= timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif
  // next state, element index and length-error pulse
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    err_len_d = 1'b0;
    case (state_q)
      LOAD: if (accept) begin
        if (idx_q == IW'(NUM_INPUTS - 1)) begin
          state_d = START;
          idx_d = '0;
          err_len_d = !in_last;
        end else begin
          idx_d = in_last ? '0 : idx_q + IW'(1);
          err_len_d = in_last;
        end
      end
      START: state_d = WAIT;
      WAIT: state_d = nn_done ? SCAN : timeout_hit ? LOAD : WAIT;
      SCAN: state_d = scan_done ? OUT : SCAN;
      OUT: state_d = res_ready ? LOAD : OUT;
      default: state_d = LOAD;
    endcase
  end
  // state, index and input vector registers; the vector only changes while loading
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= LOAD;
      idx_q     <= '0;
      vec_q     <= '0;
      err_len_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      err_len_q <= err_len_d;
      if (accept) vec_q[idx_q] <= in_data;
    end
  end
endmodule

// File: tb/tb_nn_inference_driver.sv
// tb_nn_inference_driver: randomized self-checking bench against a behavioural argmax model
module tb_nn_inference_driver;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, nn_done = 1'b0, res_ready = 1'b0;
  logic [8:0] in_data = '0;
  logic [3:0][8:0] nn_outputs = '0;
  logic in_ready, nn_start, res_valid, err_len, err_timeout;
  logic [1:0][8:0] nn_inputs;
  logic [1:0] res_class;
  logic [8:0] res_score;
  int checks = 0;
  int errors = 0;

  nn_inference_driver #(
    .FRACTION_WIDTH(4), .BIT_WIDTH(9), .NUM_INPUTS(2), .NUM_OUTPUTS(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .nn_start(nn_start), .nn_done(nn_done), .nn_inputs(nn_inputs),
    .nn_outputs(nn_outputs), .res_valid(res_valid), .res_ready(res_ready),
    .res_class(res_class), .res_score(res_score), .err_len(err_len), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sval(input logic [8:0] x);
    return x[8] ? -int'(x[7:0]) : int'(x[7:0]);
  endfunction

  function automatic int argmax4(input logic [3:0][8:0] o);
    int b = 0;
    for (int i = 1; i < 4; i++) if (sval(o[i]) > sval(o[b])) b = i;
    return b;
  endfunction

  function automatic logic [8:0] rand_elem();
    if ($urandom_range(0, 3) == 0) return $urandom_range(0, 1) == 1 ? 9'h100 : 9'h000;
    return {1'($urandom_range(0, 1)), 8'($urandom_range(0, 40))};
  endfunction

  task automatic send(input logic [8:0] d, input logic l);
    @(negedge clk);
    check("in_ready_load", in_ready, 1);
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic run_vec(input logic [8:0] a, input logic [8:0] b, input logic l2,
                         input logic [3:0][8:0] outs, input int hold);
    int ec;
    int d;
    ec = argmax4(outs);
    send(a, 1'b0);
    send(b, l2);
    check("start_pulse", nn_start, 1);
    check("vec", nn_inputs, {b, a});
    check("err_len_tail", err_len, !l2);
    d = $urandom_range(0, 3);
    repeat (d + 1) begin
      @(posedge clk);
      #1;
      check("start_once", nn_start, 0);
      check("rdy_wait", in_ready, 0);
      check("vec_hold", nn_inputs, {b, a});
    end
    @(negedge clk);
    nn_done = 1'b1;
    nn_outputs = outs;
    @(posedge clk);
    @(negedge clk);
    nn_done = 1'b0;
    nn_outputs = 36'({$urandom, $urandom});
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      check("latency", res_valid, k == 5);
    end
    check("class", res_class, ec);
    check("score", res_score, outs[ec]);
    check("no_timeout", err_timeout, 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data = rand_elem();
    repeat (hold) begin
      @(posedge clk);
      #1;
      check("hold_valid", res_valid, 1);
      check("hold_class", res_class, ec);
      check("hold_score", res_score, outs[ec]);
      check("hold_rdy", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    check("consumed", res_valid, 0);
    check("back_load", in_ready, 1);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    logic [3:0][8:0] o;
    int n;
    repeat (2) @(posedge clk);
    #1;
    check("rst_start", nn_start, 0);
    check("rst_valid", res_valid, 0);
    check("rst_rdy", in_ready, 0);
    check("rst_class", res_class, 0);
    check("rst_score", res_score, 0);
    check("rst_inputs", nn_inputs, 0);
    check("rst_errs", {err_len, err_timeout}, 0);
    @(negedge clk);
    rst = 1'b1;
    o = {rand_elem(), rand_elem(), rand_elem(), rand_elem()};
    run_vec(9'h010, 9'h110, 1'b1, o, 0);
    run_vec(9'h003, 9'h0f0, 1'b1, {9'h008, 9'h020, 9'h008, 9'h110}, 0);
    run_vec(9'h001, 9'h002, 1'b1, {9'h000, 9'h108, 9'h000, 9'h100}, 1);
    send(9'h010, 1'b1);
    check("err_len_early", err_len, 1);
    check("no_start_early", nn_start, 0);
    @(posedge clk);
    #1;
    check("err_len_pulse", err_len, 0);
    check("no_start_after", nn_start, 0);
    run_vec(9'h044, 9'h1ff, 1'b1, {9'h07f, 9'h07f, 9'h1aa, 9'h055}, 0);
    run_vec(9'h011, 9'h022, 1'b0, {9'h180, 9'h181, 9'h17f, 9'h1c0}, 0);
    run_vec(9'h0aa, 9'h155, 1'b1, {9'h033, 9'h034, 9'h033, 9'h010}, 10);
    for (int i = 0; i < 8; i++) begin
      o = {rand_elem(), rand_elem(), rand_elem(), rand_elem()};
      run_vec(rand_elem(), rand_elem(), 1'b1, o, $urandom_range(0, 3));
    end
    send(9'h0c3, 1'b0);
    send(9'h13c, 1'b1);
    @(posedge clk);
    #4;
    rst = 1'b0;
    #1;
    check("arst_inputs", nn_inputs, 0);
    check("arst_rdy", in_ready, 0);
    check("arst_start", nn_start, 0);
    check("arst_valid", res_valid, 0);
    check("arst_result", {res_class, res_score}, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_load", in_ready, 1);
`ifdef NN_DRV_TIMEOUT_EN
    send(9'h005, 1'b0);
    send(9'h006, 1'b1);
    n = 0;
    while (!err_timeout && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("timeout_cycle", n, 17);
    check("timeout_load", in_ready, 1);
    check("timeout_novalid", res_valid, 0);
    @(posedge clk);
    #1;
    check("timeout_pulse", err_timeout, 0);
`else
    n = 0;
`endif
    run_vec(9'h012, 9'h034, 1'b1, {9'h101, 9'h002, 9'h003, 9'h000}, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
